// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the single regfile write port between WB (priority) and a buffered divider result,
// tracks pending divide destinations and requests ID stalls. Optional stats: REGFILE_WPORT_ARB_STATS_EN.
module regfile_wport_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned REG_NUM      = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wreg_i,
  input  logic [ADDR_W-1:0] wb_waddr_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  input  logic              div_valid_i,
  input  logic [ADDR_W-1:0] div_waddr_i,
  input  logic [DATA_W-1:0] div_wdata_i,
  output logic              div_ready_o,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_waddr_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  input  logic              id_wreg_i,
  input  logic [ADDR_W-1:0] id_waddr_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stall_req_o
`ifdef REGFILE_WPORT_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt_o,
  output logic [15:0]       starve_cnt_o
`endif
);

  localparam int unsigned CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    STARVE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic [REG_NUM-1:0]  pending_q, pending_d;

  logic wb_busy_c;
  logic grant_c;
  logic hazard_c;

  assign wb_busy_c = wb_wreg_i && (wb_waddr_i != '0);
  assign grant_c   = !wb_busy_c && (state_q != IDLE);

  // State, buffer and scoreboard registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      pending_q  <= pending_d;
    end
  end

  // Next-state: a result to r0 is accepted but never enters HOLD, so it is dropped
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    case (state_q)
      IDLE: begin
        if (div_valid_i) begin
          buf_addr_d = div_waddr_i;
          buf_data_d = div_wdata_i;
          cnt_d      = '0;
          if (div_waddr_i != '0) state_d = HOLD;
        end
      end
      HOLD: begin
        if (grant_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STARVE_LIMIT - 1)) begin
          state_d = STARVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STARVE: begin
        if (grant_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Scoreboard update: a new issue outranks a grant clear on the same register
  always_comb begin
    pending_d = pending_q;
    if (grant_c) pending_d[buf_addr_q] = 1'b0;
    if (issue_i && (issue_waddr_i != '0)) pending_d[issue_waddr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Registers being written this cycle are forwarded by the regfile, so they never stall
  always_comb begin
    hazard_c = 1'b0;
    if (re1_i && pending_q[raddr1_i] && !(grant_c && (raddr1_i == buf_addr_q)))
      hazard_c = 1'b1;
    if (re2_i && pending_q[raddr2_i] && !(grant_c && (raddr2_i == buf_addr_q)))
      hazard_c = 1'b1;
    if (id_wreg_i && pending_q[id_waddr_i] && !(grant_c && (id_waddr_i == buf_addr_q)))
      hazard_c = 1'b1;
  end

  // Write port and handshake outputs, forced to their idle values while in reset
  always_comb begin
    we_o        = 1'b0;
    waddr_o     = '0;
    wdata_o     = '0;
    div_ready_o = 1'b1;
    stall_req_o = 1'b0;
    if (!rst) begin
      if (wb_busy_c) begin
        we_o    = 1'b1;
        waddr_o = wb_waddr_i;
        wdata_o = wb_wdata_i;
      end else if (grant_c) begin
        we_o    = 1'b1;
        waddr_o = buf_addr_q;
        wdata_o = buf_data_q;
      end
      div_ready_o = (state_q == IDLE);
      stall_req_o = hazard_c || (state_q == STARVE);
    end
  end

`ifdef REGFILE_WPORT_ARB_STATS_EN
  logic [15:0] grant_cnt_q;
  logic [15:0] starve_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (grant_c) grant_cnt_q <= grant_cnt_q + 16'd1;
      if ((state_q == HOLD) && (state_d == STARVE)) starve_cnt_q <= starve_cnt_q + 16'd1;
    end
  end

  assign grant_cnt_o  = grant_cnt_q;
  assign starve_cnt_o = starve_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed self-checking bench for regfile_wport_arbiter with hand-computed expectations.
module tb_regfile_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_wreg_i;
  logic [4:0]  wb_waddr_i;
  logic [31:0] wb_wdata_i;
  logic        div_valid_i;
  logic [4:0]  div_waddr_i;
  logic [31:0] div_wdata_i;
  logic        div_ready_o;
  logic        issue_i;
  logic [4:0]  issue_waddr_i;
  logic        re1_i, re2_i, id_wreg_i;
  logic [4:0]  raddr1_i, raddr2_i, id_waddr_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
`ifdef REGFILE_WPORT_ARB_STATS_EN
  logic [15:0] grant_cnt_o, starve_cnt_o;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  regfile_wport_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .wb_wreg_i    (wb_wreg_i),
    .wb_waddr_i   (wb_waddr_i),
    .wb_wdata_i   (wb_wdata_i),
    .div_valid_i  (div_valid_i),
    .div_waddr_i  (div_waddr_i),
    .div_wdata_i  (div_wdata_i),
    .div_ready_o  (div_ready_o),
    .issue_i      (issue_i),
    .issue_waddr_i(issue_waddr_i),
    .re1_i        (re1_i),
    .raddr1_i     (raddr1_i),
    .re2_i        (re2_i),
    .raddr2_i     (raddr2_i),
    .id_wreg_i    (id_wreg_i),
    .id_waddr_i   (id_waddr_i),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .stall_req_o  (stall_req_o)
`ifdef REGFILE_WPORT_ARB_STATS_EN
    ,
    .grant_cnt_o  (grant_cnt_o),
    .starve_cnt_o (starve_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic clr_inputs();
    wb_wreg_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;
    div_valid_i = 1'b0; div_waddr_i = '0; div_wdata_i = '0;
    issue_i = 1'b0; issue_waddr_i = '0;
    re1_i = 1'b0; raddr1_i = '0; re2_i = 1'b0; raddr2_i = '0;
    id_wreg_i = 1'b0; id_waddr_i = '0;
  endtask

  // Advance one clock, then clear inputs for the next directed step
  task automatic next_cycle();
    @(posedge clk);
    #1;
    clr_inputs();
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_wreg_i = 1'b1; wb_waddr_i = a; wb_wdata_i = d;
  endtask

  task automatic port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(we_o), 32'(we));
    chk({tag, "_waddr"}, 32'(waddr_o), 32'(a));
    chk({tag, "_wdata"}, wdata_o, d);
  endtask

  initial begin
    clr_inputs();
    // Reset with busy inputs
    rst = 1'b1;
    wb_write(5'd3, 32'h1111_1111);
    div_valid_i = 1'b1; div_waddr_i = 5'd6; div_wdata_i = 32'hDEAD_BEEF;
    issue_i = 1'b1; issue_waddr_i = 5'd5; re1_i = 1'b1; raddr1_i = 5'd5;
    @(posedge clk); #1;
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_ready", 32'(div_ready_o), 32'd1);
    chk("rst_stall", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clr_inputs();
    re1_i = 1'b1; raddr1_i = 5'd5;
    #1;
    chk("post_rst_r5_stall", 32'(stall_req_o), 32'd0);
    port("post_rst", 1'b0, 5'd0, 32'd0);
    chk("post_rst_ready", 32'(div_ready_o), 32'd1);

    // Free slot: issue r5, then divider delivers r5
    next_cycle();
    issue_i = 1'b1; issue_waddr_i = 5'd5;
    next_cycle();
    div_valid_i = 1'b1; div_waddr_i = 5'd5; div_wdata_i = 32'h0000_0064;
    re1_i = 1'b1; raddr1_i = 5'd5;
    #1;
    chk("free_accept_ready", 32'(div_ready_o), 32'd1);
    chk("free_pending_stall", 32'(stall_req_o), 32'd1);
    next_cycle();
    re1_i = 1'b1; raddr1_i = 5'd5;
    #1;
    chk("free_hold_ready", 32'(div_ready_o), 32'd0);
    port("free_grant", 1'b1, 5'd5, 32'h0000_0064);
    chk("free_grant_nostall", 32'(stall_req_o), 32'd0);
    next_cycle();
    re1_i = 1'b1; raddr1_i = 5'd5;
    #1;
    chk("free_after_ready", 32'(div_ready_o), 32'd1);
    chk("free_after_stall", 32'(stall_req_o), 32'd0);
    port("free_after", 1'b0, 5'd0, 32'd0);

    // WB priority: buffer r7 blocked by two WB writes
    next_cycle();
    div_valid_i = 1'b1; div_waddr_i = 5'd7; div_wdata_i = 32'hAAAA_AAAA;
    next_cycle();
    wb_write(5'd3, 32'h0000_0011);
    #1;
    port("prio_wb1", 1'b1, 5'd3, 32'h0000_0011);
    chk("prio_wb1_stall", 32'(stall_req_o), 32'd0);
    next_cycle();
    wb_write(5'd3, 32'h0000_0022);
    #1;
    port("prio_wb2", 1'b1, 5'd3, 32'h0000_0022);
    chk("prio_wb2_stall", 32'(stall_req_o), 32'd0);
    next_cycle();
    #1;
    port("prio_grant", 1'b1, 5'd7, 32'hAAAA_AAAA);
    chk("prio_grant_stall", 32'(stall_req_o), 32'd0);
    next_cycle();
    #1;
    chk("prio_after_ready", 32'(div_ready_o), 32'd1);

    // Starvation: four blocked cycles push HOLD into STARVE
    next_cycle();
    div_valid_i = 1'b1; div_waddr_i = 5'd8; div_wdata_i = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      wb_write(5'd2, 32'(i));
      #1;
      chk($sformatf("starve_blk%0d_stall", i), 32'(stall_req_o), 32'd0);
      chk($sformatf("starve_blk%0d_waddr", i), 32'(waddr_o), 32'd2);
    end
    next_cycle();
    wb_write(5'd2, 32'h0000_00FF);
    #1;
    chk("starve_state_stall", 32'(stall_req_o), 32'd1);
    port("starve_wb", 1'b1, 5'd2, 32'h0000_00FF);
    next_cycle();
    #1;
    chk("starve_grant_stall", 32'(stall_req_o), 32'd1);
    port("starve_grant", 1'b1, 5'd8, 32'h1234_5678);
    next_cycle();
    #1;
    chk("starve_exit_stall", 32'(stall_req_o), 32'd0);
    chk("starve_exit_ready", 32'(div_ready_o), 32'd1);

    // Hazard on pending r9 (RAW on port 2, WAW on ID destination)
    next_cycle();
    issue_i = 1'b1; issue_waddr_i = 5'd9;
    re2_i = 1'b1; raddr2_i = 5'd9;
    #1;
    chk("haz_issue_cycle_stall", 32'(stall_req_o), 32'd0);
    next_cycle();
    re2_i = 1'b1; raddr2_i = 5'd9;
    #1;
    chk("haz_raw_stall", 32'(stall_req_o), 32'd1);
    next_cycle();
    id_wreg_i = 1'b1; id_waddr_i = 5'd9;
    #1;
    chk("haz_waw_stall", 32'(stall_req_o), 32'd1);
    next_cycle();
    re2_i = 1'b1; raddr2_i = 5'd10;
    #1;
    chk("haz_other_reg_stall", 32'(stall_req_o), 32'd0);
    next_cycle();
    div_valid_i = 1'b1; div_waddr_i = 5'd9; div_wdata_i = 32'h0000_0099;
    re2_i = 1'b1; raddr2_i = 5'd9;
    #1;
    chk("haz_accept_stall", 32'(stall_req_o), 32'd1);
    next_cycle();
    re2_i = 1'b1; raddr2_i = 5'd9;
    #1;
    chk("haz_grant_stall", 32'(stall_req_o), 32'd0);
    port("haz_grant", 1'b1, 5'd9, 32'h0000_0099);
    next_cycle();
    re2_i = 1'b1; raddr2_i = 5'd9;
    #1;
    chk("haz_cleared_stall", 32'(stall_req_o), 32'd0);

    // Divider result to r0 is dropped
    next_cycle();
    div_valid_i = 1'b1; div_waddr_i = 5'd0; div_wdata_i = 32'h0000_00FF;
    #1;
    chk("r0_accept_ready", 32'(div_ready_o), 32'd1);
    port("r0_accept", 1'b0, 5'd0, 32'd0);
    next_cycle();
    #1;
    port("r0_next", 1'b0, 5'd0, 32'd0);
    chk("r0_next_ready", 32'(div_ready_o), 32'd1);

    // Issue r4 in the same cycle r4 is granted: set wins
    next_cycle();
    issue_i = 1'b1; issue_waddr_i = 5'd4;
    next_cycle();
    div_valid_i = 1'b1; div_waddr_i = 5'd4; div_wdata_i = 32'h0000_0044;
    next_cycle();
    issue_i = 1'b1; issue_waddr_i = 5'd4;
    re1_i = 1'b1; raddr1_i = 5'd4;
    #1;
    port("setwin_grant", 1'b1, 5'd4, 32'h0000_0044);
    chk("setwin_grant_stall", 32'(stall_req_o), 32'd0);
    next_cycle();
    re1_i = 1'b1; raddr1_i = 5'd4;
    #1;
    chk("setwin_pending_stall", 32'(stall_req_o), 32'd1);

    next_cycle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the single regfile write port between the pipeline WB stage and a long-latency result source (divider, valid/ready handshake).
- Holds one divider result in a buffer until WB leaves the port free.
- Keeps a per-register pending scoreboard and raises a stall request to ID for hazards on pending registers.
- Sits between the MEM/WB register, the divider, the regfile write port and the pipeline stall controller.

Parameters:
- STARVE_LIMIT, 4: consecutive blocked cycles in HOLD before entering STARVE and forcing bubbles (minimum 1).
- REG_NUM, 32: number of architectural registers.
- ADDR_W, 5: register address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- wb_wreg_i  in  1  WB write enable
- wb_waddr_i  in  ADDR_W  WB destination address
- wb_wdata_i  in  DATA_W  WB write data
- div_valid_i  in  1  divider result valid
- div_waddr_i  in  ADDR_W  divider destination address
- div_wdata_i  in  DATA_W  divider result
- div_ready_o  out  1  buffer can accept a divider result
- issue_i  in  1  ID dispatches a divide this cycle
- issue_waddr_i  in  ADDR_W  destination of the dispatched divide
- re1_i / raddr1_i  in  1 / ADDR_W  ID read port 1 enable and address
- re2_i / raddr2_i  in  1 / ADDR_W  ID read port 2 enable and address
- id_wreg_i / id_waddr_i  in  1 / ADDR_W  ID instruction destination enable and address
- we_o  out  1  regfile write enable
- waddr_o  out  ADDR_W  regfile write address
- wdata_o  out  DATA_W  regfile write data
- stall_req_o  out  1  stall request to the pipeline controller

Behaviour:
- Reset: synchronous, active-high on rst. Sets state IDLE, buffer empty, starve counter 0, all pending bits 0. Outputs during and after reset until the next event: we_o=0, waddr_o=0, wdata_o=0, div_ready_o=1, stall_req_o=0.
- WB slot is busy when wb_wreg_i=1 and wb_waddr_i!=0. WB always has priority and is never delayed.
- Write port outputs are combinational:
  - WB busy: drive WB values.
  - WB free and state HOLD/STARVE: drive the buffer (this is a grant).
  - Otherwise: we_o=0, waddr_o=0, wdata_o=0.
- FSM:
  - IDLE: div_ready_o=1. On div_valid_i=1, latch addr/data into the buffer, clear the counter, go to HOLD. Minimum latency from accept to write is 1 cycle; no pass-through.
  - HOLD: div_ready_o=0. On grant, go to IDLE. Otherwise increment the counter; when the counter reaches STARVE_LIMIT-1 while blocked, go to STARVE.
  - STARVE: div_ready_o=0, stall_req_o forced to 1. On grant, go to IDLE and clear the counter.
- A divider result with address 0 is accepted and dropped: return to IDLE next cycle, we_o stays 0.
- Scoreboard:
  - issue_i with issue_waddr_i!=0 sets pending[issue_waddr_i] at the edge.
  - A grant clears pending[buffer addr] at the edge.
  - Set and clear on the same address in the same cycle: set wins.
  - pending[0] is always 0.
- Hazard stall (combinational), asserted when any of these holds:
  - re1_i && pending[raddr1_i]
  - re2_i && pending[raddr2_i]
  - id_wreg_i && pending[id_waddr_i] (WAW; also blocks a second divide to the same register)
- Exception: a register being granted in the current cycle does not cause a hazard stall, because the regfile forwards it from the write port.
- stall_req_o = hazard stall OR (state==STARVE).
- Reset mid-operation drops the buffered result and all pending bits.

Optional Feature:
- Macro: REGFILE_WPORT_ARB_STATS_EN.
- Defined: adds outputs grant_cnt_o[15:0] (divider writes granted) and starve_cnt_o[15:0] (entries into STARVE). Both are wrapping counters, zeroed by rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with arbitrary inputs -> we_o=0, div_ready_o=1, stall_req_o=0; all pending bits clear (a read of r5 does not stall).
- Free slot: issue_i r5, then div_valid_i r5=0x0000_0064 with WB idle -> div_ready_o=0 next cycle; we_o=1, waddr_o=5, wdata_o=0x64 one cycle after accept; pending[5] cleared; div_ready_o=1 again.
- WB priority: buffer holds r7=0xAAAA_AAAA; WB writes r3 for 2 cycles then idles -> port shows r3 twice, then r7=0xAAAA_AAAA; no stall (2 < STARVE_LIMIT).
- Starvation: buffer full; WB writes every cycle for 4 cycles -> STARVE entered after 4 blocked cycles, stall_req_o=1; first WB-free cycle grants the buffer; stall_req_o drops the next cycle.
- Hazard: pending r9 with re2_i=1, raddr2_i=9 -> stall_req_o=1 until the grant cycle of r9, where it is 0; id_wreg_i with id_waddr_i=9 while pending -> stall_req_o=1.
- Edge cases: divider result to r0 -> we_o never 1 and the FSM returns to IDLE; issue_i r4 in the same cycle as a grant of r4 -> pending[4] remains 1.
